// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
// Shared types and constants for the pipeline sequencing controller.
//   pipe_state_t : FSM state encoding (RUN, BUBBLE, WAIT), observable on the state port.
//   pipe_ctrl_t  : bundle of the five register enables and three bubble flushes.
//   CTRL_*       : the fixed control patterns the decoder chooses between.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        PIPE_RUN    = 2'd0,
        PIPE_BUBBLE = 2'd1,
        PIPE_WAIT   = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
    } pipe_ctrl_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Everything held, every stage loads a bubble while reset is asserted.
    localparam pipe_ctrl_t CTRL_RESET     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    // Memory not ready: nothing advances, WB receives a bubble so no retire repeats.
    localparam pipe_ctrl_t CTRL_FREEZE    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    // Redirect: kill the two wrong-path instructions in IF/ID and ID/EX.
    localparam pipe_ctrl_t CTRL_REDIRECT  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    // Load-use: hold PC and IF/ID, push a bubble into EX.
    localparam pipe_ctrl_t CTRL_LOAD_USE  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam pipe_ctrl_t CTRL_NORMAL    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if
// Bundles the controller's hazard inputs and pipeline control outputs.
//   Inputs to controller : id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
//                          ex_rd_addr, ex_mem_read, ex_redirect, dmem_req, dmem_ready
//   Outputs              : five register enables, three flushes, state,
//                          stall_cnt, flush_cnt, mem_timeout
//   modport master : pipeline side (drives hazard inputs, consumes controls)
//   modport slave  : the controller itself
// CNT_W must match the CNT_W of the pipeline_ctrl instance attached to it.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1_addr;
    logic [4:0]       id_rs2_addr;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       ex_rd_addr;
    logic             ex_mem_read;
    logic             ex_redirect;
    logic             dmem_req;
    logic             dmem_ready;

    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mem_wb_flush;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             mem_timeout;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
               ex_rd_addr, ex_mem_read, ex_redirect, dmem_req, dmem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, mem_wb_flush,
               state, stall_cnt, flush_cnt, mem_timeout
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
               ex_rd_addr, ex_mem_read, ex_redirect, dmem_req, dmem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, mem_wb_flush,
               state, stall_cnt, flush_cnt, mem_timeout
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect
// Purely combinational load-use detector between ID and EX.
//   rs1_addr, rs2_addr   : source fields of the ID instruction
//   uses_rs1, uses_rs2   : whether ID actually reads each source
//   ex_rd_addr           : destination of the EX instruction
//   ex_mem_read          : EX instruction is a load
//   load_use             : ID needs a value the EX load has not produced yet
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    input  logic       uses_rs1,
    input  logic       uses_rs2,
    input  logic [4:0] ex_rd_addr,
    input  logic       ex_mem_read,
    output logic       load_use
);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use = ex_mem_read && (ex_rd_addr != REG_ZERO) &&
                      ((uses_rs1 && (rs1_addr == ex_rd_addr)) ||
                       (uses_rs2 && (rs2_addr == ex_rd_addr)));

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Pipeline sequencing controller for the 5-stage core. Resolves memory
// freezes, EX redirects and load-use hazards (in that priority) into
// register enables and bubble flushes, and keeps stall/flush counters plus
// a sticky memory-timeout flag.
//   clk, reset_n : clock and asynchronous active-low reset
//   bus          : pipeline_ctrl_if slave (hazard inputs, control outputs,
//                  state, stall_cnt, flush_cnt, mem_timeout)
// Parameters: MEM_TIMEOUT consecutive wait cycles before mem_timeout is set,
//             CNT_W width of the performance counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    pipeline_ctrl_if.slave   bus
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    pipe_state_t       state_q;
    pipe_state_t       state_d;
    pipe_ctrl_t        ctrl;
    logic              freeze;
    logic              load_use;
    logic [WAIT_W-1:0] wait_q;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  flush_q;
    logic              timeout_q;

    hazard_detect u_hazard_detect (
        .rs1_addr    (bus.id_rs1_addr),
        .rs2_addr    (bus.id_rs2_addr),
        .uses_rs1    (bus.id_uses_rs1),
        .uses_rs2    (bus.id_uses_rs2),
        .ex_rd_addr  (bus.ex_rd_addr),
        .ex_mem_read (bus.ex_mem_read),
        .load_use    (load_use)
    );

    assign freeze = bus.dmem_req && !bus.dmem_ready;

    // Mealy decode. RUN, BUBBLE and WAIT all decode identically; the state
    // only records what the previous cycle did. Reset overrides the decode so
    // the pipeline is held and bubbled the instant reset_n falls.
    always_comb begin
        ctrl    = CTRL_NORMAL;
        state_d = PIPE_RUN;
        if (!reset_n) begin
            ctrl    = CTRL_RESET;
            state_d = PIPE_RUN;
        end else if (freeze) begin
            ctrl    = CTRL_FREEZE;
            state_d = PIPE_WAIT;
        end else if (bus.ex_redirect) begin
            // A load-use seen now involves a wrong-path ID instruction, so it is dropped.
            ctrl    = CTRL_REDIRECT;
            state_d = PIPE_RUN;
        end else if (load_use) begin
            ctrl    = CTRL_LOAD_USE;
            state_d = PIPE_BUBBLE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= PIPE_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Saturating performance counters and the memory wait watchdog. A redirect
    // blocked by a freeze is only counted in the cycle it is actually applied.
    // The timeout flag is set on the edge that completes the MEM_TIMEOUT-th
    // consecutive frozen cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q   <= '0;
            flush_q   <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (!ctrl.pc_en && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (!freeze && bus.ex_redirect && (flush_q != '1)) begin
                flush_q <= flush_q + 1'b1;
            end
            if (freeze) begin
                if (wait_q != WAIT_MAX) begin
                    wait_q <= wait_q + 1'b1;
                end
                if (wait_q >= WAIT_LAST) begin
                    timeout_q <= 1'b1;
                end
            end else begin
                wait_q <= '0;
            end
        end
    end

    assign bus.pc_en        = ctrl.pc_en;
    assign bus.if_id_en     = ctrl.if_id_en;
    assign bus.id_ex_en     = ctrl.id_ex_en;
    assign bus.ex_mem_en    = ctrl.ex_mem_en;
    assign bus.mem_wb_en    = ctrl.mem_wb_en;
    assign bus.if_id_flush  = ctrl.if_id_flush;
    assign bus.id_ex_flush  = ctrl.id_ex_flush;
    assign bus.mem_wb_flush = ctrl.mem_wb_flush;
    assign bus.state        = state_q;
    assign bus.stall_cnt    = stall_q;
    assign bus.flush_cnt    = flush_q;
    assign bus.mem_timeout  = timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
// Scoreboard bench for pipeline_ctrl. The driver applies one input vector per
// cycle at the falling edge and pushes the response a reference model predicts;
// a monitor samples the DUT shortly after and compares against the queue head.
module tb_pipeline_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 8;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [7:0]       ctrl;
        logic [1:0]       state;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
        logic             timeout;
        int               cyc;
    } exp_t;

    logic clk;
    logic reset_n;

    pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    exp_t exp_q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   cycle_no     = 0;

    // Reference model state: what the design's registers hold right now.
    int m_state   = 0;
    int m_stall   = 0;
    int m_flush   = 0;
    int m_consec  = 0;
    int m_timeout = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int cyc,
                                input logic [31:0] got, input logic [31:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, want);
        end
    endtask

    // One cycle of stimulus. The expected outputs are worked out from the
    // hazard rules: pick the winning condition, look up what the pipeline
    // should do, then advance the counters as the coming edge would.
    task automatic apply_stimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic u1, input logic u2,
                                  input logic [4:0] rd, input logic mr,
                                  input logic redir, input logic req,
                                  input logic rdy, input logic rst_n);
        exp_t e;
        bit   frz;
        bit   hz;
        int   nxt;
        @(negedge clk);
        cycle_no++;
        bus.id_rs1_addr = rs1;
        bus.id_rs2_addr = rs2;
        bus.id_uses_rs1 = u1;
        bus.id_uses_rs2 = u2;
        bus.ex_rd_addr  = rd;
        bus.ex_mem_read = mr;
        bus.ex_redirect = redir;
        bus.dmem_req    = req;
        bus.dmem_ready  = rdy;
        reset_n         = rst_n;
        e.cyc = cycle_no;
        if (!rst_n) begin
            m_state = 0; m_stall = 0; m_flush = 0; m_consec = 0; m_timeout = 0;
            e.ctrl    = 8'b00000_111;
            e.state   = 2'd0;
            e.stall   = '0;
            e.flush   = '0;
            e.timeout = 1'b0;
            exp_q.push_back(e);
            return;
        end
        frz = req && !rdy;
        hz  = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        if (frz) begin
            e.ctrl = 8'b00000_001; nxt = 2;
        end else if (redir) begin
            e.ctrl = 8'b11111_110; nxt = 0;
        end else if (hz) begin
            e.ctrl = 8'b00111_010; nxt = 1;
        end else begin
            e.ctrl = 8'b11111_000; nxt = 0;
        end
        e.state   = 2'(m_state);
        e.stall   = CNT_W'(m_stall);
        e.flush   = CNT_W'(m_flush);
        e.timeout = m_timeout[0];
        exp_q.push_back(e);
        if (!e.ctrl[7]) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
        if (!frz && redir) m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
        m_consec = frz ? m_consec + 1 : 0;
        if (m_consec >= MEM_TIMEOUT) m_timeout = 1;
        m_state = nxt;
    endtask

    task automatic idle_cycle(input logic rst_n);
        apply_stimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, rst_n);
    endtask

    // Monitor: shortly after each falling edge, compare the DUT against the
    // oldest outstanding prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("ctrl", e.cyc,
                             32'({bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en,
                                  bus.mem_wb_en, bus.if_id_flush, bus.id_ex_flush,
                                  bus.mem_wb_flush}), 32'(e.ctrl));
                check_output("state", e.cyc, 32'(bus.state), 32'(e.state));
                check_output("stall_cnt", e.cyc, 32'(bus.stall_cnt), 32'(e.stall));
                check_output("flush_cnt", e.cyc, 32'(bus.flush_cnt), 32'(e.flush));
                check_output("mem_timeout", e.cyc, 32'(bus.mem_timeout), 32'(e.timeout));
            end
        end
    end

    // Watchdog so a stuck run still terminates with a verdict.
    initial begin
        #2000000;
        n_mismatched++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [4:0] a1, a2, rd;
        bit         req;
        reset_n = 1'b0;
        bus.id_rs1_addr = '0; bus.id_rs2_addr = '0;
        bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
        bus.ex_rd_addr = '0; bus.ex_mem_read = 1'b0; bus.ex_redirect = 1'b0;
        bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;

        idle_cycle(1'b0);
        idle_cycle(1'b0);
        idle_cycle(1'b1);

        // Load-use on rs2, then EX holds the bubble.
        apply_stimulus(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_cycle(1'b1);
        // No hazard through x0 or an unused source; rs1 hazard.
        apply_stimulus(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(5'd1, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(5'd7, 5'd1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_cycle(1'b1);
        // Redirect masks a load-use.
        apply_stimulus(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        idle_cycle(1'b1);
        // Ready in the same cycle as the request: no freeze.
        apply_stimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        // Three frozen cycles with a redirect pending, then release.
        repeat (3) apply_stimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        apply_stimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        idle_cycle(1'b1);
        // Six frozen cycles trip the timeout, which stays sticky.
        repeat (6) apply_stimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        apply_stimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (3) idle_cycle(1'b1);
        // Reset between edges in the middle of a wait.
        repeat (2) apply_stimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        apply_stimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_cycle(1'b1);
        // Saturation of both counters.
        repeat (CNT_MAX + 5) apply_stimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (CNT_MAX + 5) apply_stimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle_cycle(1'b0);

        // Randomized traffic over a small register window so hazards are common.
        for (int i = 0; i < 3000; i++) begin
            a1  = 5'($urandom_range(0, 3));
            a2  = 5'($urandom_range(0, 3));
            rd  = 5'($urandom_range(0, 3));
            req = ($urandom_range(0, 2) == 0);
            apply_stimulus(a1, a2, 1'($urandom), 1'($urandom), rd,
                           ($urandom_range(0, 1) == 0), ($urandom_range(0, 5) == 0),
                           req, ($urandom_range(0, 2) == 0),
                           ($urandom_range(0, 199) != 0));
        end

        @(negedge clk);
        #4;
        check_output("queue_drained", cycle_no, 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
